mmu_wait_state: RTL and testbench

//  Consumes the active-low chip enables from the address-decode MMU and stretches slow-device
//  bus cycles by pulling the CPU RDY line low for a per-device number of wait cycles.
//  It also generates read/write strobes for the selected device.

---
 rtl/mmu_wait_state.sv | 148 ++++++++++++++
 tb/tb_mmu_wait_state.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_wait_state.sv
// Wait-state generator between the MMU chip enables and the 65C02 RDY pin.
// Also produces the read/write strobes for the selected device.
module mmu_wait_state #(
  parameter int EEPROM_WAIT = 2,
  parameter int RAM_WAIT    = 0,
  parameter int VIA_WAIT    = 1,
  parameter int ACIA_WAIT   = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eeprom_ce_n,
  input  logic        ram_ce_n,
  input  logic        via_ce_n,
  input  logic        acia_ce_n,
  input  logic        rw,
  input  logic        wait_en,
  output logic        rdy,
  output logic        oe_n,
  output logic        we_n,
  output logic [15:0] wait_count,
  output logic        decode_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] EE_N   = CNT_W'(EEPROM_WAIT);
  localparam logic [CNT_W-1:0] RAM_N  = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] VIA_N  = CNT_W'(VIA_WAIT);
  localparam logic [CNT_W-1:0] ACIA_N = CNT_W'(ACIA_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [3:0]       dev_q, dev_d;
  logic [15:0]      wcnt_q;
  logic             err_q;

  logic [3:0]       ce;
  logic             any_ce;
  logic             one_hot;
  logic             multi;
  logic [CNT_W-1:0] n_sel;
  logic             abort;
  logic             complete;

  assign ce      = ~{acia_ce_n, via_ce_n, ram_ce_n, eeprom_ce_n};
  assign any_ce  = |ce;
  assign one_hot = any_ce && ((ce & (ce - 4'd1)) == 4'd0);
  assign multi   = any_ce && !one_hot;
  // abort when the device that started the wait drops its select
  assign abort   = |(dev_q & ~ce);

  always_comb begin
    n_sel = '0;
    if (one_hot && wait_en) begin
      unique case (1'b1)
        ce[0]:   n_sel = EE_N;
        ce[1]:   n_sel = RAM_N;
        ce[2]:   n_sel = VIA_N;
        ce[3]:   n_sel = ACIA_N;
        default: n_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      dev_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      dev_q   <= dev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    dev_d   = dev_q;
    unique case (state_q)
      S_IDLE: begin
        if (n_sel != '0) begin
          state_d = S_WAIT;
          cnt_d   = n_sel - 1'b1;
          rdy_d   = 1'b0;
          dev_d   = ce;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rdy_d   = 1'b1;
          dev_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
          dev_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rdy_d   = 1'b1;
        dev_d   = '0;
      end
    endcase
  end

  always_comb begin
    complete = (state_q == S_DONE) ||
               (state_q == S_IDLE && n_sel == '0);
    oe_n     = !(any_ce && rw);
    we_n     = !(any_ce && !rw && complete);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!rdy_q && wcnt_q != 16'hFFFF)
        wcnt_q <= wcnt_q + 16'd1;
      if (multi)
        err_q <= 1'b1;
    end
  end

  assign rdy          = rdy_q;
  assign wait_count   = wcnt_q;
  assign decode_error = err_q;

endmodule

// File: tb/tb_mmu_wait_state.sv
// Bench for mmu_wait_state: behavioural model plus directed
// literal checks, random traffic and a counter saturation run.
module tb_mmu_wait_state;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, eeprom_ce_n, ram_ce_n, via_ce_n, acia_ce_n;
  logic        rw, wait_en;
  logic        rdy, oe_n, we_n, decode_error;
  logic [15:0] wait_count;

  logic        b_reset, b_eeprom_ce_n, b_ram_ce_n, b_via_ce_n;
  logic        b_acia_ce_n, b_rw, b_wait_en;
  logic        b_rdy, b_oe_n, b_we_n, b_decode_error;
  logic [15:0] b_wait_count;

  mmu_wait_state dut (
    .clk(clk), .reset(reset),
    .eeprom_ce_n(eeprom_ce_n), .ram_ce_n(ram_ce_n),
    .via_ce_n(via_ce_n), .acia_ce_n(acia_ce_n),
    .rw(rw), .wait_en(wait_en),
    .rdy(rdy), .oe_n(oe_n), .we_n(we_n),
    .wait_count(wait_count), .decode_error(decode_error)
  );

  mmu_wait_state #(.EEPROM_WAIT(33000), .CNT_W(16)) dut_sat (
    .clk(clk), .reset(b_reset),
    .eeprom_ce_n(b_eeprom_ce_n), .ram_ce_n(b_ram_ce_n),
    .via_ce_n(b_via_ce_n), .acia_ce_n(b_acia_ce_n),
    .rw(b_rw), .wait_en(b_wait_en),
    .rdy(b_rdy), .oe_n(b_oe_n), .we_n(b_we_n),
    .wait_count(b_wait_count), .decode_error(b_decode_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // model: busy = inside the wait stretch, rem = waits left
  bit m_busy = 0, m_done = 0, m_err = 0;
  int m_rem = 0, m_dev = 0, m_cnt = 0;

  logic        s_rdy, s_oe, s_we, s_err;
  logic [15:0] s_cnt;

  function automatic int wait_of(input int d);
    case (d)
      0: return 2;
      1: return 0;
      2: return 1;
      default: return 1;
    endcase
  endfunction

  task automatic cycle(input bit rst, input logic [3:0] s,
                       input bit r, input bit we);
    int low, idx, n;
    bit e_oe, e_we;
    @(negedge clk);
    reset = rst;
    {acia_ce_n, via_ce_n, ram_ce_n, eeprom_ce_n} = ~s;
    rw = r;
    wait_en = we;
    #1;
    low = $countones(s);
    idx = 0;
    for (int i = 0; i < 4; i++) if (s[i]) idx = i;
    n = (low == 1 && we) ? wait_of(idx) : 0;
    e_oe = !(low > 0 && r);
    e_we = !(low > 0 && !r && (m_done || (!m_busy && n == 0)));
    chk("rdy", rdy, !m_busy);
    chk("oe_n", oe_n, e_oe);
    chk("we_n", we_n, e_we);
    chk("wait_count", wait_count, m_cnt);
    chk("decode_error", decode_error, m_err);
    s_rdy = rdy; s_oe = oe_n; s_we = we_n;
    s_err = decode_error; s_cnt = wait_count;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0;
      m_rem = 0; m_cnt = 0;
    end else begin
      if (m_busy && m_cnt < 65535) m_cnt++;
      if (low > 1) m_err = 1;
      if (m_busy) begin
        if (!s[m_dev]) m_busy = 0;
        else if (m_rem == 1) begin
          m_busy = 0;
          m_done = 1;
        end else m_rem--;
      end else if (m_done) m_done = 0;
      else if (n > 0) begin
        m_busy = 1;
        m_rem = n;
        m_dev = idx;
      end
    end
  endtask

  logic [11:0] pat;
  logic [2:0]  wpat;
  logic        oe_acc;
  logic [3:0]  cur_s;
  bit          cur_r, cur_we;
  int          n0, n1;

  initial begin
    reset = 1; rw = 1; wait_en = 1;
    {acia_ce_n, via_ce_n, ram_ce_n, eeprom_ce_n} = 4'hF;
    b_reset = 1; b_rw = 1; b_wait_en = 1;
    {b_acia_ce_n, b_via_ce_n, b_ram_ce_n, b_eeprom_ce_n} = 4'hF;
    repeat (2) @(posedge clk);

    // reset state and EEPROM read
    cycle(1, 4'b0000, 1, 1);
    cycle(0, 4'b0000, 1, 1);
    chk("rst_rdy", s_rdy, 1);
    chk("rst_oe", s_oe, 1);
    chk("rst_we", s_we, 1);
    chk("rst_cnt", s_cnt, 0);
    chk("rst_err", s_err, 0);
    oe_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 4'b0001, 1, 1);
      pat[3-i] = s_rdy;
      oe_acc = oe_acc | s_oe;
    end
    chk("ee_rdy_pat", pat[3:0], 4'b1001);
    chk("ee_oe_low", oe_acc, 0);
    cycle(0, 4'b0000, 1, 1);
    chk("ee_cnt", s_cnt, 2);

    // RAM write: no wait, strobe in same cycle
    cycle(0, 4'b0010, 0, 1);
    chk("ram_rdy", s_rdy, 1);
    chk("ram_we", s_we, 0);
    cycle(0, 4'b0000, 1, 1);
    chk("ram_cnt", s_cnt, 2);
    chk("ram_rdy2", s_rdy, 1);

    // three back-to-back EEPROM fetches
    cycle(1, 4'b0000, 1, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 4'b0001, 1, 1);
      pat[11-i] = s_rdy;
    end
    chk("b2b_pat", pat, 12'b1001_1001_1001);
    cycle(0, 4'b0000, 1, 1);
    chk("b2b_cnt", s_cnt, 6);

    // VIA write, bypass then with waits
    cycle(0, 4'b0100, 0, 0);
    chk("via0_rdy", s_rdy, 1);
    chk("via0_we", s_we, 0);
    cycle(0, 4'b0000, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 4'b0100, 0, 1);
      pat[2-i] = s_rdy;
      wpat[2-i] = s_we;
    end
    chk("via1_rdy", pat[2:0], 3'b101);
    chk("via1_we", wpat, 3'b110);
    cycle(0, 4'b0000, 1, 1);
    chk("via1_cnt", s_cnt, 7);

    // double select
    cycle(1, 4'b0000, 1, 1);
    cycle(0, 4'b1010, 1, 1);
    chk("dbl_rdy", s_rdy, 1);
    cycle(0, 4'b0000, 1, 1);
    chk("dbl_err", s_err, 1);
    chk("dbl_rdy2", s_rdy, 1);
    repeat (3) cycle(0, 4'b0000, 1, 1);
    chk("dbl_err_sticky", s_err, 1);
    chk("dbl_cnt", s_cnt, 0);

    // reset in first wait cycle
    cycle(1, 4'b0000, 1, 1);
    cycle(0, 4'b0001, 1, 1);
    cycle(1, 4'b0001, 1, 1);
    chk("rw_rdy_low", s_rdy, 0);
    cycle(0, 4'b0000, 1, 1);
    chk("rw_rdy", s_rdy, 1);
    chk("rw_oe", s_oe, 1);
    chk("rw_we", s_we, 1);
    chk("rw_cnt", s_cnt, 0);

    // randomized traffic against the model
    cur_s = 0; cur_r = 1; cur_we = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 30) begin
        int m;
        m = $urandom_range(99);
        if (m < 20) cur_s = 4'b0000;
        else if (m < 94) cur_s = 4'b0001 << $urandom_range(3);
        else cur_s = 4'($urandom_range(15));
        cur_r = 1'($urandom_range(1));
        if ($urandom_range(9) == 0) cur_we = !cur_we;
      end
      cycle($urandom_range(99) < 2, cur_s, cur_r, cur_we);
    end
    reset = 0;
    {acia_ce_n, via_ce_n, ram_ce_n, eeprom_ce_n} = 4'hF;

    // saturation on a long-wait instance
    @(negedge clk);
    b_reset = 0;
    b_eeprom_ce_n = 0;
    n0 = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (!b_rdy) n0++;
      else if (n0 > 0) break;
    end
    chk("sat_len1", n0, 33000);
    chk("sat_cnt1", b_wait_count, 33000);
    n1 = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (!b_rdy) n1++;
      else if (n1 > 0) break;
    end
    chk("sat_len2", n1, 33000);
    chk("sat_cnt2", b_wait_count, 16'hFFFF);
    repeat (50) @(negedge clk);
    chk("sat_hold", b_wait_count, 16'hFFFF);
    chk("sat_rdy_low", b_rdy, 0);
    b_eeprom_ce_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
